// File: rtl/reg_array_sequencer.sv
// reg_array_sequencer
//   Control stage in front of the 8 x 14-bit register array. It accepts an
//   instruction over a valid/ready handshake and sequences it through
//   IDLE -> DECODE -> (EXEC | MEM) -> WB. Along the way it drives the array's
//   load strobes, read selects, ALU code, rin write data and RAM requests.
//   Optional feature macro: REG_SEQ_MEM_TIMEOUT_EN. When it is defined, the
//   MEM wait is bounded to TIMEOUT cycles and err_timeout is a sticky error.
//   Without it, MEM waits indefinitely and err_timeout is tied low.
//   rst is synchronous and active-low.

module reg_array_sequencer #(
   parameter int DATA_W  = 14,
   parameter int NREG    = 8,
   parameter int TIMEOUT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       instr,
   input  logic                    instr_valid,
   output logic                    instr_ready,
   input  logic [DATA_W-1:0]       mem_rdata,
   input  logic                    mem_ack,
   output logic                    mem_rd,
   output logic                    mem_wr,
   output logic [DATA_W-1:0]       rin_out,
   output logic [NREG-1:0]         ldR,
   output logic [NREG-1:0]         ldALU,
   output logic [$clog2(NREG)-1:0] selrd1,
   output logic [$clog2(NREG)-1:0] selrd2,
   output logic [$clog2(NREG)-1:0] selram,
   output logic [2:0]              alu_op,
   output logic                    busy,
   output logic                    halted,
   output logic                    illegal,
   output logic                    err_timeout
);

   localparam int RW = $clog2(NREG);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] instr_reg;
   logic [DATA_W-1:0] rin_reg;
   logic              fire;
   logic              mem_expired;

   // Decoded fields of the latched instruction
   logic [3:0]        op_f;
   logic [RW-1:0]     rd_f;
   logic [NREG-1:0]   rd_onehot;
   logic              is_ldi, is_load, is_store, is_halt, is_nop, is_alu, is_undef;

   assign op_f     = instr_reg[13:10];
   assign rd_f     = instr_reg[9:7];
   assign is_nop   = (op_f == 4'b0000);
   assign is_ldi   = (op_f == 4'b0001);
   assign is_load  = (op_f == 4'b0010);
   assign is_store = (op_f == 4'b0011);
   assign is_halt  = (op_f == 4'b0100);
   assign is_alu   = op_f[3];
   assign is_undef = !(is_nop || is_ldi || is_load || is_store || is_halt || is_alu);

   // The selects come straight from the latched word. They are loaded at the
   // handshake edge, so they are valid from DECODE and hold until the next
   // accept.
   assign selrd1  = instr_reg[6:4];
   assign selrd2  = instr_reg[3:1];
   assign selram  = instr_reg[3:1];
   assign alu_op  = is_alu ? op_f[2:0] : 3'b000;
   assign rin_out = rin_reg;

   // One decoder per register for the writeback strobe
   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_rd_dec
         assign rd_onehot[gi] = (rd_f == RW'(gi));
      end
   endgenerate

   // instr_ready is already gated by rst, so a handshake never fires during reset
   assign fire = instr_valid && instr_ready;

`ifdef REG_SEQ_MEM_TIMEOUT_EN
   logic [3:0] cnt_reg;
   logic       err_reg;

   // The counter holds the number of MEM cycles already spent. It reaches
   // TIMEOUT-1 in the TIMEOUT-th MEM cycle, and that is the last cycle in
   // which an ack is still accepted.
   assign mem_expired = (cnt_reg == 4'(TIMEOUT - 1));
   assign err_timeout = err_reg;

   // MEM cycle counter; it is cleared whenever the FSM is outside MEM
   always_ff @(posedge clk) begin
      if (!rst)                 cnt_reg <= 4'd0;
      else if (state_reg == S_MEM) cnt_reg <= cnt_reg + 4'd1;
      else                      cnt_reg <= 4'd0;
   end

   // Sticky timeout flag; an ack in the final cycle takes priority over expiry
   always_ff @(posedge clk) begin
      if (!rst)
         err_reg <= 1'b0;
      else if (state_reg == S_MEM && !mem_ack && mem_expired)
         err_reg <= 1'b1;
   end
`else
   assign mem_expired = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_reg <= S_IDLE;
      else      state_reg <= state_next;
   end

   // Instruction latch and rin write-data register
   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_reg <= '0;
         rin_reg   <= '0;
      end else begin
         if (fire)
            instr_reg <= instr;
         if (state_reg == S_DECODE && is_ldi)
            rin_reg <= {{(DATA_W-7){1'b0}}, instr_reg[6:0]};
         else if (state_reg == S_MEM && is_load && mem_ack)
            rin_reg <= mem_rdata;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:   if (fire) state_next = S_DECODE;
         S_DECODE: begin
            if (is_ldi)                   state_next = S_WB;
            else if (is_alu)              state_next = S_EXEC;
            else if (is_load || is_store) state_next = S_MEM;
            else if (is_halt)             state_next = S_HALT;
            else                          state_next = S_IDLE;
         end
         S_EXEC:   state_next = S_WB;
         S_MEM: begin
            if (mem_ack)          state_next = is_load ? S_WB : S_IDLE;
            else if (mem_expired) state_next = S_IDLE;
         end
         S_WB:     state_next = S_IDLE;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from the current state and the latched opcode
   always_comb begin
      instr_ready = 1'b0;
      busy        = 1'b0;
      halted      = 1'b0;
      illegal     = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      ldR         = '0;
      ldALU       = '0;
      instr_ready = (state_reg == S_IDLE) && rst;
      busy        = (state_reg != S_IDLE);
      halted      = (state_reg == S_HALT);
      illegal     = (state_reg == S_DECODE) && is_undef;
      mem_rd      = (state_reg == S_MEM) && is_load;
      mem_wr      = (state_reg == S_MEM) && is_store;
      if (state_reg == S_WB) begin
         if (is_alu)                ldALU = rd_onehot;
         else if (is_ldi || is_load) ldR  = rd_onehot;
      end
   end

endmodule

// File: doc/reg_array_sequencer.md
Name: reg_array_sequencer

Overview:
- Control stage directly upstream of the 8 x 14-bit register array.
- Accepts 14-bit instructions over a valid/ready handshake and decodes them.
- Sequences each instruction through a small multi-cycle FSM.
- Drives the array's one-hot load strobes (ldR, ldALU), its three read selects, the immediate/memory write-data path (rin), and the RAM request handshake.

Parameters:
- DATA_W, 14, datapath/instruction width; must match the register array.
- NREG, 8, register count; register fields are log2(NREG)=3 bits.
- TIMEOUT, 15, memory-wait cycle limit; used only when the optional feature is enabled.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-low reset.
- instr  input  14  instruction word.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  sequencer can accept instr.
- mem_rdata  input  14  RAM read data.
- mem_ack  input  1  RAM completes the current request.
- mem_rd  output  1  RAM read request, level-held.
- mem_wr  output  1  RAM write request, level-held; write data is the array's ramOut.
- rin_out  output  14  write data for the array's rin input.
- ldR  output  8  one-hot register load from rin.
- ldALU  output  8  one-hot register load from the ALU result.
- selrd1  output  3  read select for operand/address port 1.
- selrd2  output  3  read select for operand port 2.
- selram  output  3  read select for the RAM data port.
- alu_op  output  3  ALU function code.
- busy  output  1  state is not IDLE.
- halted  output  1  HALT executed.
- illegal  output  1  one-cycle pulse on an undefined opcode.
- err_timeout  output  1  sticky memory-timeout flag.

Behaviour:
- Instruction format:
  - op = [13:10], rd = [9:7], rs1 = [6:4], rs2 = [3:1]; bit [0] is ignored.
  - imm7 = [6:0], zero-extended to 14 bits.
- Opcodes:
  - 0000 NOP.
  - 0001 LDI: rd <- imm7.
  - 0010 LOAD: rd <- RAM[R[rs1]].
  - 0011 STORE: RAM[R[rs1]] <- R[rs2].
  - 1000-1111 ALU: alu_op = op[2:0], rd <- R[rs1] op R[rs2].
  - 0100 HALT.
  - 0101-0111 undefined.
- States: IDLE, DECODE, EXEC, MEM, WB, HALT.
- IDLE:
  - instr_ready = 1 (combinational from state, gated by rst=1).
  - Handshake fires when instr_valid and instr_ready are both 1 at a rising edge; instr is latched and the FSM moves to DECODE.
- DECODE (1 cycle):
  - Drives selrd1=rs1, selrd2=rs2, selram=rs2, alu_op.
  - These outputs then hold constant until the FSM returns to IDLE.
  - Next state: LDI -> WB, with rin_out = imm7 zero-extended. ALU -> EXEC. LOAD/STORE -> MEM. HALT -> HALT. NOP -> IDLE.
  - Undefined opcode: illegal pulses for 1 cycle, then -> IDLE.
- EXEC (1 cycle): covers the array's registered read-mux latency, then -> WB.
- MEM:
  - mem_rd (LOAD) or mem_wr (STORE) is held high until mem_ack is sampled high; an ack on the first MEM cycle is legal.
  - LOAD: on the ack edge, mem_rdata is latched into rin_out, then -> WB.
  - STORE: -> IDLE on the ack edge.
  - mem_ack outside MEM is ignored.
- WB (1 cycle):
  - Exactly one bit of ldR (LDI/LOAD) or ldALU (ALU) is high, at index rd. Then -> IDLE.
  - ldR and ldALU are never both nonzero; outside WB both are 0.
- Latency from the handshake edge T:
  - ALU: ldALU strobe in cycle T+3, IDLE at T+4.
  - LDI: ldR strobe at T+2.
  - LOAD: ldR strobe 1 cycle after the ack cycle.
  - NOP: IDLE at T+2.
- HALT: halted=1 and instr_ready=0; only reset exits this state.
- Reset (rst=0 at an edge, in any state, including mid-MEM):
  - State -> IDLE.
  - ldR, ldALU, selects, alu_op, rin_out, mem_rd, mem_wr, busy, halted, illegal, err_timeout all -> 0.
  - Any in-flight writeback is discarded.

Optional Feature:
- Macro: REG_SEQ_MEM_TIMEOUT_EN.
- Enabled:
  - A 4-bit counter increments each cycle spent in MEM.
  - If TIMEOUT cycles elapse without mem_ack: mem_rd/mem_wr drop, err_timeout sets (sticky until reset), no WB occurs, and the FSM returns to IDLE.
  - An ack in the same cycle the count reaches TIMEOUT counts as success.
- Disabled: MEM waits indefinitely; err_timeout is tied to 0.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> all outputs 0, instr_ready=1, busy=0.
- LDI: instr=0x04A5 (LDI, rd=1, imm=0x25) -> ldR=8'h02 and rin_out=14'h0025 in cycle T+2 only; instr_ready=1 again at T+3.
- ALU: instr=0x2316 (op=1000, rd=6, rs1=1, rs2=3) -> selrd1=1, selrd2=3, alu_op=0 from T+1; ldALU=8'h40 at T+3 only.
- LOAD: rd=2, rs1=5; mem_ack after 3 wait cycles with mem_rdata=0x1ABC -> mem_rd high 4 cycles; then ldR=8'h04 with rin_out=0x1ABC.
- STORE: rs1=4, rs2=7; ack on the first MEM cycle -> mem_wr high 1 cycle, selram=7, no ld strobe. Then HALT -> halted=1, instr_ready=0, instr_valid ignored.
- Reset asserted in the second MEM cycle of a LOAD -> mem_rd=0 next edge, no ldR strobe. With REG_SEQ_MEM_TIMEOUT_EN and no ack -> err_timeout=1 after 15 MEM cycles, FSM returns to IDLE.
